sd_bd_scheduler: RTL and testbench

Sequences queued buffer descriptors (BDs) from the RX and TX BD memories into SD block transfers. Arbitrates round-robin between the two queues and fetches a 4-word descriptor. Issues the single-block command through the write_req_s/cmd_set_s/cmd_arg_s path of the Wishbone register block, then starts and supervises the data phase. Reports completion and errors through a BD interrupt status register, which drives Bd_isr_reg.

---
 rtl/sd_bd_scheduler.sv | 172 +++++++++++++++++
 tb/tb_sd_bd_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_bd_scheduler.sv
// sd_bd_scheduler: round-robin RX/TX BD fetch, single-block command issue,
// data-phase supervision with watchdog and a sticky BD interrupt status.
module sd_bd_scheduler #(
  parameter int          MEM_W       = 16,
  parameter logic [15:0] CMD_SET_TX  = 16'h181A,
  parameter logic [15:0] CMD_SET_RX  = 16'h111A,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4095
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             sched_en,
  input  logic             tx_bd_empty,
  input  logic             rx_bd_empty,
  output logic             re_tx_bd,
  output logic             re_rx_bd,
  input  logic [MEM_W-1:0] dat_tx_bd,
  input  logic [MEM_W-1:0] dat_rx_bd,
  output logic             write_req_s,
  output logic [15:0]      cmd_set_s,
  output logic [31:0]      cmd_arg_s,
  input  logic             we_ack,
  input  logic             cmd_done,
  input  logic             cmd_err,
  output logic             start_tx,
  output logic             start_rx,
  output logic [31:0]      sys_adr,
  input  logic             data_done,
  input  logic             data_crc_err,
  input  logic             Bd_isr_reset,
  input  logic [7:0]       Bd_isr_enable_reg,
  output logic [7:0]       Bd_isr_reg,
  output logic             int_o,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CMD_REQ, S_CMD_WAIT, S_DATA, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic        dir_q, dir_d;
  logic        last_srv_q, last_srv_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] sys_adr_q, sys_adr_d;
  logic [31:0] card_adr_q, card_adr_d;
  logic [4:0]  isr_q, isr_d, isr_set;
  logic        start_tx_q, start_tx_d;
  logic        start_rx_q, start_rx_d;
  logic [15:0] wd;
  logic        watched, tmo;

  // dir/last_srv: 1 = TX, 0 = RX
  assign wd = dir_q ? dat_tx_bd[15:0] : dat_rx_bd[15:0];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      dir_q      <= 1'b0;
      last_srv_q <= 1'b0;
      timer_q    <= '0;
      sys_adr_q  <= '0;
      card_adr_q <= '0;
      isr_q      <= '0;
      start_tx_q <= 1'b0;
      start_rx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      dir_q      <= dir_d;
      last_srv_q <= last_srv_d;
      timer_q    <= timer_d;
      sys_adr_q  <= sys_adr_d;
      card_adr_q <= card_adr_d;
      isr_q      <= isr_d;
      start_tx_q <= start_tx_d;
      start_rx_q <= start_rx_d;
    end
  end

  always_comb begin
    watched    = (state_q == S_CMD_REQ) || (state_q == S_CMD_WAIT) ||
                 (state_q == S_DATA);
    tmo        = watched && (timer_q == TIMEOUT_CYC);
    state_d    = state_q;
    k_d        = k_q;
    dir_d      = dir_q;
    last_srv_d = last_srv_q;
    sys_adr_d  = sys_adr_q;
    card_adr_d = card_adr_q;
    isr_set    = '0;
    start_tx_d = 1'b0;
    start_rx_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sched_en && !(tx_bd_empty && rx_bd_empty)) begin
          dir_d   = (!tx_bd_empty && !rx_bd_empty) ? !last_srv_q
                                                   : !tx_bd_empty;
          k_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        k_d = k_q + 3'd1;
        unique case (k_q)
          3'd1: sys_adr_d[15:0]   = wd;
          3'd2: sys_adr_d[31:16]  = wd;
          3'd3: card_adr_d[15:0]  = wd;
          3'd4: begin
            card_adr_d[31:16] = wd;
            state_d           = S_CMD_REQ;
          end
          default: ;
        endcase
      end
      S_CMD_REQ: begin
        if (we_ack) state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (cmd_err) begin
          isr_set[2] = 1'b1;
          state_d    = S_DONE;
        end else if (cmd_done) begin
          start_tx_d = dir_q;
          start_rx_d = !dir_q;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (data_done) begin
          if (data_crc_err) isr_set[3] = 1'b1;
          else if (dir_q)   isr_set[0] = 1'b1;
          else              isr_set[1] = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_srv_d = dir_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog abandons the descriptor; no retry.
    if (tmo) begin
      isr_set    = 5'b10000;
      start_tx_d = 1'b0;
      start_rx_d = 1'b0;
      state_d    = S_DONE;
    end
    if (state_d != state_q) timer_d = '0;
    else if (watched)       timer_d = timer_q + 16'd1;
    else                    timer_d = '0;
    isr_d = (Bd_isr_reset ? 5'd0 : isr_q) | isr_set;
  end

  always_comb begin
    re_tx_bd    = (state_q == S_FETCH) && (k_q != 3'd4) && dir_q;
    re_rx_bd    = (state_q == S_FETCH) && (k_q != 3'd4) && !dir_q;
    write_req_s = (state_q == S_CMD_REQ);
    cmd_set_s   = (state_q == S_CMD_REQ) ?
                  (dir_q ? CMD_SET_TX : CMD_SET_RX) : 16'h0;
    cmd_arg_s   = (state_q == S_CMD_REQ) ? card_adr_q : 32'h0;
    start_tx    = start_tx_q;
    start_rx    = start_rx_q;
    sys_adr     = sys_adr_q;
    Bd_isr_reg  = {3'b000, isr_q};
    int_o       = |({3'b000, isr_q} & Bd_isr_enable_reg);
    busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_sd_bd_scheduler.sv
// Bench for sd_bd_scheduler: BD memory model, directed scenarios and
// randomized descriptor batches checked against a transaction-level model.
module tb_sd_bd_scheduler;

  localparam logic [15:0] TX_SET = 16'h181A;
  localparam logic [15:0] RX_SET = 16'h111A;
  localparam int          TMO    = 4095;

  logic        clk = 1'b0;
  logic        wb_rst_i, sched_en;
  logic        tx_bd_empty, rx_bd_empty;
  logic        re_tx_bd, re_rx_bd;
  logic [15:0] dat_tx_bd = '0, dat_rx_bd = '0;
  logic        write_req_s;
  logic [15:0] cmd_set_s;
  logic [31:0] cmd_arg_s;
  logic        we_ack, cmd_done, cmd_err;
  logic        start_tx, start_rx;
  logic [31:0] sys_adr;
  logic        data_done, data_crc_err;
  logic        Bd_isr_reset;
  logic [7:0]  Bd_isr_enable_reg;
  logic [7:0]  Bd_isr_reg;
  logic        int_o, busy;

  always #5 clk = ~clk;

  sd_bd_scheduler dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (wb_rst_i),
    .sched_en          (sched_en),
    .tx_bd_empty       (tx_bd_empty),
    .rx_bd_empty       (rx_bd_empty),
    .re_tx_bd          (re_tx_bd),
    .re_rx_bd          (re_rx_bd),
    .dat_tx_bd         (dat_tx_bd),
    .dat_rx_bd         (dat_rx_bd),
    .write_req_s       (write_req_s),
    .cmd_set_s         (cmd_set_s),
    .cmd_arg_s         (cmd_arg_s),
    .we_ack            (we_ack),
    .cmd_done          (cmd_done),
    .cmd_err           (cmd_err),
    .start_tx          (start_tx),
    .start_rx          (start_rx),
    .sys_adr           (sys_adr),
    .data_done         (data_done),
    .data_crc_err      (data_crc_err),
    .Bd_isr_reset      (Bd_isr_reset),
    .Bd_isr_enable_reg (Bd_isr_enable_reg),
    .Bd_isr_reg        (Bd_isr_reg),
    .int_o             (int_o),
    .busy              (busy)
  );

  // BD memories: registered read, one word per strobe
  logic [15:0] tx_mem [0:255];
  logic [15:0] rx_mem [0:255];
  int tx_wr = 0, tx_rd = 0, rx_wr = 0, rx_rd = 0;
  int n_re_tx = 0, n_re_rx = 0;

  assign tx_bd_empty = (tx_rd >= tx_wr);
  assign rx_bd_empty = (rx_rd >= rx_wr);

  always @(posedge clk) begin
    if (re_tx_bd) begin
      dat_tx_bd <= tx_mem[tx_rd];
      tx_rd     <= tx_rd + 1;
      n_re_tx   <= n_re_tx + 1;
    end
    if (re_rx_bd) begin
      dat_rx_bd <= rx_mem[rx_rd];
      rx_rd     <= rx_rd + 1;
      n_re_rx   <= n_re_rx + 1;
    end
  end

  // Reference model: pending descriptors {card, sys}, last served, ISR
  logic [63:0] mq_tx[$];
  logic [63:0] mq_rx[$];
  bit          m_last_tx = 1'b0;
  logic [7:0]  m_isr = '0;
  int          m_srv_tx = 0, m_srv_rx = 0;

  int n_chk = 0, n_ok = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {re_tx_bd, re_rx_bd, write_req_s, start_tx,
        start_rx, int_o, busy, Bd_isr_reg, cmd_set_s}, 0);
    chk({tag, "_adr"}, {cmd_arg_s, sys_adr}, 0);
  endtask

  function automatic bit pick_tx();
    if (mq_tx.size() != 0 && mq_rx.size() != 0) return !m_last_tx;
    return mq_tx.size() != 0;
  endfunction

  task automatic push(input bit tx, input logic [31:0] sa,
                      input logic [31:0] ca);
    if (tx) begin
      tx_mem[tx_wr]   = sa[15:0];
      tx_mem[tx_wr+1] = sa[31:16];
      tx_mem[tx_wr+2] = ca[15:0];
      tx_mem[tx_wr+3] = ca[31:16];
      tx_wr += 4;
      mq_tx.push_back({ca, sa});
    end else begin
      rx_mem[rx_wr]   = sa[15:0];
      rx_mem[rx_wr+1] = sa[31:16];
      rx_mem[rx_wr+2] = ca[15:0];
      rx_mem[rx_wr+3] = ca[31:16];
      rx_wr += 4;
      mq_rx.push_back({ca, sa});
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk) wb_rst_i = 1'b1;
    @(negedge clk) wb_rst_i = 1'b0;
    m_isr     = '0;
    m_last_tx = 1'b0;
  endtask

  task automatic isr_clr();
    @(negedge clk) Bd_isr_reset = 1'b1;
    @(negedge clk) Bd_isr_reset = 1'b0;
    m_isr = '0;
    chk("isr_clr", Bd_isr_reg, m_isr);
  endtask

  // mode: 0 ok, 1 cmd_err+cmd_done, 2 no ack, 3 crc err,
  //       4 reset in DATA, 5 ISR reset with data_done
  task automatic serve(input int mode, input int ack_dly, input bit drop_en);
    bit          tx;
    logic [63:0] d;
    int          n;
    tx = pick_tx();
    if (tx) begin d = mq_tx.pop_front(); m_srv_tx++; end
    else    begin d = mq_rx.pop_front(); m_srv_rx++; end
    n = 0;
    while (!write_req_s && n < 100) begin @(negedge clk); n++; end
    chk("req_seen", write_req_s, 1);
    if (!write_req_s) return;
    if (drop_en) sched_en = 1'b0;
    chk("re_tx_cnt", n_re_tx, 4 * m_srv_tx);
    chk("re_rx_cnt", n_re_rx, 4 * m_srv_rx);
    chk("cmd_set", cmd_set_s, tx ? TX_SET : RX_SET);
    chk("cmd_arg", cmd_arg_s, d[63:32]);
    chk("sys_adr", sys_adr, d[31:0]);
    if (mode == 2) begin
      n = 0;
      while (write_req_s && n < 5000) begin @(negedge clk); n++; end
      chk("req_hold", n, TMO + 1);
      m_isr[4]  = 1'b1;
      m_last_tx = tx;
      chk("isr_tmo", Bd_isr_reg, m_isr);
      return;
    end
    n = (ack_dly < 0) ? $urandom_range(0, 4) : ack_dly;
    repeat (n) @(negedge clk);
    chk("req_held", {write_req_s, cmd_set_s, cmd_arg_s},
        {1'b1, tx ? TX_SET : RX_SET, d[63:32]});
    we_ack = 1'b1;
    @(negedge clk) we_ack = 1'b0;
    chk("req_drop", write_req_s, 0);
    n = $urandom_range(0, 3);
    repeat (n) @(negedge clk);
    cmd_done = 1'b1;
    cmd_err  = (mode == 1);
    @(negedge clk);
    cmd_done = 1'b0;
    cmd_err  = 1'b0;
    if (mode == 1) begin
      m_isr[2]  = 1'b1;
      m_last_tx = tx;
      chk("err_nostart", {start_tx, start_rx}, 0);
      chk("isr_cmderr", Bd_isr_reg, m_isr);
      chk("err_done", busy, 1);
      @(negedge clk);
      chk("err_idle", busy, 0);
      return;
    end
    chk("start", {start_tx, start_rx}, {tx, !tx});
    @(negedge clk);
    chk("start_1cyc", {start_tx, start_rx}, 0);
    if (mode == 4) begin
      wb_rst_i = 1'b1;
      #1;
      chk_zero("rst_mid");
      m_isr     = '0;
      m_last_tx = 1'b0;
      @(negedge clk) wb_rst_i = 1'b0;
      return;
    end
    n = $urandom_range(0, 3);
    repeat (n) @(negedge clk);
    data_done    = 1'b1;
    data_crc_err = (mode == 3);
    Bd_isr_reset = (mode == 5);
    @(negedge clk);
    data_done    = 1'b0;
    data_crc_err = 1'b0;
    Bd_isr_reset = 1'b0;
    if (mode == 5) m_isr = '0;
    if (mode == 3) m_isr[3] = 1'b1;
    else if (tx)   m_isr[0] = 1'b1;
    else           m_isr[1] = 1'b1;
    m_last_tx = tx;
    chk("isr", Bd_isr_reg, m_isr);
    chk("int_o", int_o, |(m_isr & Bd_isr_enable_reg));
    chk("done_busy", busy, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    int md;
    wb_rst_i = 1'b1; sched_en = 1'b0;
    we_ack = 1'b0; cmd_done = 1'b0; cmd_err = 1'b0;
    data_done = 1'b0; data_crc_err = 1'b0;
    Bd_isr_reset = 1'b0; Bd_isr_enable_reg = 8'h00;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    wb_rst_i = 1'b0;
    @(negedge clk);

    // stray pulses in IDLE are ignored
    we_ack = 1'b1; cmd_done = 1'b1; data_done = 1'b1;
    @(negedge clk);
    we_ack = 1'b0; cmd_done = 1'b0; data_done = 1'b0;
    @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_isr", Bd_isr_reg, m_isr);

    // single TX descriptor, start blocked until sched_en
    Bd_isr_enable_reg = 8'h01;
    push(1'b1, 32'h0000_1000, 32'h0000_0008);
    repeat (3) @(negedge clk);
    chk("en_block", busy, 0);
    sched_en = 1'b1;
    serve(0, 3, 1'b0);
    chk("isr_tx_only", Bd_isr_reg, 8'h01);
    chk("int_tx_only", int_o, 1);

    // both queues pending: alternation starting with TX after reset
    sched_en = 1'b0;
    rst_pulse();
    push(1'b1, $urandom, $urandom);
    push(1'b0, $urandom, $urandom);
    push(1'b1, $urandom, $urandom);
    push(1'b0, $urandom, $urandom);
    sched_en = 1'b1;
    repeat (4) serve(0, -1, 1'b0);
    chk("isr_both", Bd_isr_reg, 8'h03);

    // cmd_err beats cmd_done
    isr_clr();
    push(1'b0, $urandom, $urandom);
    serve(1, -1, 1'b0);

    // missing we_ack, then a normal descriptor
    push(1'b1, $urandom, $urandom);
    push(1'b1, $urandom, $urandom);
    serve(2, 0, 1'b0);
    serve(0, -1, 1'b0);

    // data CRC error, then ISR reset colliding with a set
    isr_clr();
    push(1'b0, $urandom, $urandom);
    serve(3, -1, 1'b0);
    chk("isr_crc", Bd_isr_reg, 8'h08);
    push(1'b1, $urandom, $urandom);
    serve(5, -1, 1'b0);
    chk("isr_set_wins", Bd_isr_reg, 8'h01);

    // sched_en dropped mid-transfer
    sched_en = 1'b0;
    push(1'b1, $urandom, $urandom);
    push(1'b0, $urandom, $urandom);
    sched_en = 1'b1;
    serve(0, -1, 1'b1);
    repeat (4) @(negedge clk);
    chk("en_drop_idle", busy, 0);
    chk("en_drop_nofetch", n_re_tx + n_re_rx, 4 * (m_srv_tx + m_srv_rx));
    sched_en = 1'b1;
    serve(0, -1, 1'b0);

    // reset during DATA restores TX-first arbitration
    push(1'b1, $urandom, $urandom);
    serve(0, -1, 1'b0);
    sched_en = 1'b0;
    push(1'b0, $urandom, $urandom);
    push(1'b1, $urandom, $urandom);
    push(1'b0, $urandom, $urandom);
    sched_en = 1'b1;
    serve(4, -1, 1'b0);
    repeat (2) serve(0, -1, 1'b0);

    // randomized batches
    Bd_isr_enable_reg = 8'hFF;
    for (int b = 0; b < 8; b++) begin
      sched_en = 1'b0;
      if ($urandom_range(0, 1) == 1) isr_clr();
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++)
        push($urandom_range(0, 1) == 1, $urandom, $urandom);
      sched_en = 1'b1;
      for (int i = 0; i < nb; i++) begin
        md = $urandom_range(0, 2);
        serve((md == 2) ? 3 : md, -1, 1'b0);
      end
    end
    repeat (4) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
